ripple_carry_adder: RTL and testbench
=====================================

Name: ripple_carry_adder

Overview:
Parameterised N-bit ripple-carry adder with carry-in, carry-out and signed-overflow flag.
- The combinational ripple chain is built from one full-adder cell per bit.
- Results are captured in an output register qualified by a valid strobe.
- Used as a small arithmetic primitive in datapaths, e.g. counter/offset arithmetic; default configuration is 2 bits.

Parameters:
- WIDTH, 2, operand and sum width in bits; legal range 1..64.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands valid this cycle; result captured on next rising edge.
- a  input  WIDTH  operand A, unsigned or two's complement.
- b  input  WIDTH  operand B, unsigned or two's complement.
- cin  input  1  carry into bit 0.
- sum  output  WIDTH  registered sum bits, a + b + cin modulo 2^WIDTH.
- c_out  output  1  registered carry out of the MSB.
- overflow  output  1  registered signed overflow: carry into MSB XOR carry out of MSB.
- out_valid  output  1  registered; high for one cycle per accepted operand set.

Behaviour:
- Reset:
  - rst_n low clears sum, c_out, overflow and out_valid to 0 immediately, independent of clk.
  - Release is synchronised by the integrating design; the block itself does no synchronisation.
- Arithmetic:
  - c[0] = cin.
  - Per bit i: s[i] = a[i]^b[i]^c[i] and c[i+1] = a[i]&b[i] | c[i]&(a[i]^b[i]).
  - c_out = c[WIDTH]; overflow = c[WIDTH] ^ c[WIDTH-1].
  - {c_out, sum} always equals a + b + cin exactly, with no saturation.
  - For WIDTH=1: overflow = c[1]^c[0].
- Latency: exactly 1 cycle.
  - On a rising edge with in_valid=1, the next-state values load into sum/c_out/overflow and out_valid goes 1.
- Idle:
  - On a rising edge with in_valid=0, out_valid goes 0.
  - sum/c_out/overflow hold their last captured values.
- Throughput: one operation per cycle; back-to-back in_valid is fully supported with no stall and no backpressure.
- Boundary cases:
  - Maximum input, all-ones + all-ones + 1, gives sum all-ones and c_out=1.
  - Zero input gives all zeros.
- Reset mid-operation: a pending capture is discarded; out_valid stays 0 until the first valid edge after rst_n rises.
- X on operands while in_valid=0 must not propagate into the held result registers.

Decomposition:
- No shared package is needed. Optionally define a WIDTH default constant in the project arithmetic package if one already exists.
- One sub-module, full_adder: inputs a, b, cin; outputs s, cout; purely combinational.
  - Instantiated WIDTH times in a generate loop, chained cout to next cin.
- Top level holds the carry vector, the overflow XOR and the output register stage.

Test Plan:
- Reset: hold rst_n=0 with in_valid=1, a=2'b11, b=2'b11, cin=1 -> sum=00, c_out=0, overflow=0, out_valid=0; all remain 0 until an edge after release.
- Directed vectors, WIDTH=2, one per cycle, in_valid=1:
  - 01+11+1 -> sum=01, c_out=1, overflow=0.
  - 11+11+1 -> sum=11, c_out=1, overflow=0.
  - 10+01+0 -> sum=11, c_out=0, overflow=0.
  - 00+11+0 -> sum=11, c_out=0, overflow=0.
  - Each result appears one cycle after its inputs, with out_valid=1 on every cycle.
- Signed overflow, WIDTH=2: 01+01+0 -> sum=10, c_out=0, overflow=1; 10+10+0 -> sum=00, c_out=1, overflow=1.
- Hold/valid: apply 01+11+1, then in_valid=0 with a=b=00 for 3 cycles -> out_valid pulses for one cycle; sum=01 and c_out=1 held throughout.
- Async reset mid-stream: assert rst_n=0 between clock edges during back-to-back traffic -> outputs clear before the next edge; first valid after release produces the correct result.
- Exhaustive/random, WIDTH=2 and WIDTH=8: compare {c_out,sum} against a+b+cin for all 32 combinations (WIDTH=2) and 10k random vectors (WIDTH=8); also check overflow against a signed reference model.

Source files
------------

// File: rtl/ripple_carry_adder_pkg.sv
// ripple_carry_adder_pkg: shared constants for the ripple-carry adder slice.
//   DEFAULT_WIDTH - default operand/sum width used by ripple_carry_adder.
package ripple_carry_adder_pkg;
    localparam int DEFAULT_WIDTH = 2;
endpackage

// File: rtl/full_adder.sv
// full_adder: one-bit combinational full-adder cell.
//   a, b  - operand bits
//   cin   - carry in
//   s     - sum bit
//   cout  - carry out
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/ripple_carry_adder.sv
// ripple_carry_adder: WIDTH-bit ripple-carry adder with a registered result stage.
//   clk, rst_n - clock, asynchronous active-low reset
//   in_valid   - operands valid; result captured on the next rising edge
//   a, b, cin  - operands and carry in
//   sum        - registered a + b + cin modulo 2^WIDTH
//   c_out      - registered carry out of the MSB
//   overflow   - registered signed overflow (carry into MSB ^ carry out of MSB)
//   out_valid  - one-cycle strobe per accepted operand set
module ripple_carry_adder
    import ripple_carry_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             overflow,
    output logic             out_valid
);
    logic [WIDTH:0]   w_c;
    logic [WIDTH-1:0] w_s;
    logic             w_ovf;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_ovf;
    logic             r_valid;

    assign w_c[0] = cin;

    genvar i;
    generate
        for (i = 0; i < WIDTH; i++) begin : g_fa
            full_adder u_fa (
                .a   (a[i]),
                .b   (b[i]),
                .cin (w_c[i]),
                .s   (w_s[i]),
                .cout(w_c[i+1])
            );
        end
    endgenerate

    // For WIDTH=1 the carry into the MSB is cin itself, which w_c[0] already holds.
    assign w_ovf = w_c[WIDTH] ^ w_c[WIDTH-1];

    // Result registers load only on accepted operands, so idle-cycle operand
    // values (including X) never reach the held outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= in_valid;
            if (in_valid) begin
                r_sum  <= w_s;
                r_cout <= w_c[WIDTH];
                r_ovf  <= w_ovf;
            end
        end
    end

    assign sum       = r_sum;
    assign c_out     = r_cout;
    assign overflow  = r_ovf;
    assign out_valid = r_valid;
endmodule

// File: tb/tb_ripple_carry_adder.sv
// tb_ripple_carry_adder: randomized and directed checks of 2-bit and 8-bit adders against an arithmetic model.
module tb_ripple_carry_adder;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       v2 = 1'b0, cin2 = 1'b0;
    logic [1:0] a2 = '0, b2 = '0;
    logic [1:0] s2;
    logic       co2, ov2, vo2;
    logic       v8 = 1'b0, cin8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic [7:0] s8;
    logic       co8, ov8, vo8;
    int checks = 0;
    int errors = 0;
    int e2_sum = 0, e2_c = 0, e2_ov = 0, e2_v = 0;
    int e8_sum = 0, e8_c = 0, e8_ov = 0, e8_v = 0;

    ripple_carry_adder u_dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(v2), .a(a2), .b(b2), .cin(cin2),
        .sum(s2), .c_out(co2), .overflow(ov2), .out_valid(vo2)
    );

    ripple_carry_adder #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(v8), .a(a8), .b(b8), .cin(cin8),
        .sum(s8), .c_out(co8), .overflow(ov8), .out_valid(vo8)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Unsigned and signed integer arithmetic, independent of any carry chain.
    task automatic ref_add(input int w, input int a, input int b, input int c,
                           output int s, output int co, output int ov);
        int full, sa, sb, ss;
        full = a + b + c;
        s    = full % (1 << w);
        co   = full >> w;
        sa   = (a >= (1 << (w - 1))) ? a - (1 << w) : a;
        sb   = (b >= (1 << (w - 1))) ? b - (1 << w) : b;
        ss   = sa + sb + c;
        ov   = (ss > (1 << (w - 1)) - 1 || ss < -(1 << (w - 1))) ? 1 : 0;
    endtask

    task automatic clear_model();
        e2_sum = 0; e2_c = 0; e2_ov = 0; e2_v = 0;
        e8_sum = 0; e8_c = 0; e8_ov = 0; e8_v = 0;
    endtask

    task automatic check_all(input string tag);
        chk({tag, " w2 sum"}, 16'(s2), 16'(e2_sum));
        chk({tag, " w2 cout"}, 16'(co2), 16'(e2_c));
        chk({tag, " w2 ovf"}, 16'(ov2), 16'(e2_ov));
        chk({tag, " w2 vld"}, 16'(vo2), 16'(e2_v));
        chk({tag, " w8 sum"}, 16'(s8), 16'(e8_sum));
        chk({tag, " w8 cout"}, 16'(co8), 16'(e8_c));
        chk({tag, " w8 ovf"}, 16'(ov8), 16'(e8_ov));
        chk({tag, " w8 vld"}, 16'(vo8), 16'(e8_v));
    endtask

    task automatic drive(input string tag, input bit sel8, input bit v,
                         input int a, input int b, input int c);
        if (sel8) begin
            v8 = v; a8 = a[7:0]; b8 = b[7:0]; cin8 = c[0]; v2 = 1'b0;
        end else begin
            v2 = v; a2 = a[1:0]; b2 = b[1:0]; cin2 = c[0]; v8 = 1'b0;
        end
        @(posedge clk);
        #1;
        if (!rst_n) clear_model();
        else begin
            e2_v = (!sel8 && v) ? 1 : 0;
            e8_v = (sel8 && v) ? 1 : 0;
            if (!sel8 && v) ref_add(2, a & 3, b & 3, c & 1, e2_sum, e2_c, e2_ov);
            if (sel8 && v) ref_add(8, a & 255, b & 255, c & 1, e8_sum, e8_c, e8_ov);
        end
        check_all(tag);
    endtask

    // a, b, cin, sum, c_out, overflow
    int tbl[6][6] = '{
        '{1, 3, 1, 1, 1, 0},
        '{3, 3, 1, 3, 1, 0},
        '{2, 1, 0, 3, 0, 0},
        '{0, 3, 0, 3, 0, 0},
        '{1, 1, 0, 2, 0, 1},
        '{2, 2, 0, 0, 1, 1}
    };

    initial begin
        v2 = 1'b1; a2 = 2'b11; b2 = 2'b11; cin2 = 1'b1;
        v8 = 1'b1; a8 = 8'hff; b8 = 8'hff; cin8 = 1'b1;
        #1;
        check_all("rst0");
        repeat (2) @(posedge clk);
        #1;
        check_all("rst_hold");
        @(negedge clk);
        rst_n = 1'b1;
        v8 = 1'b0;
        #1;
        check_all("rst_rel");
        for (int i = 0; i < 6; i++) begin
            drive("dir", 1'b0, 1'b1, tbl[i][0], tbl[i][1], tbl[i][2]);
            chk("dir tbl sum", 16'(s2), 16'(tbl[i][3]));
            chk("dir tbl cout", 16'(co2), 16'(tbl[i][4]));
            chk("dir tbl ovf", 16'(ov2), 16'(tbl[i][5]));
        end
        drive("hold_ld", 1'b0, 1'b1, 1, 3, 1);
        for (int i = 0; i < 3; i++) begin
            drive("hold", 1'b0, 1'b0, 0, 0, 0);
            chk("hold sum", 16'(s2), 16'd1);
            chk("hold cout", 16'(co2), 16'd1);
        end
        drive("arst_pre", 1'b0, 1'b1, 2, 1, 0);
        drive("arst_pre", 1'b0, 1'b1, 3, 3, 1);
        #3;
        rst_n = 1'b0;
        clear_model();
        #1;
        check_all("arst_async");
        drive("arst_in", 1'b0, 1'b1, 3, 3, 1);
        @(negedge clk);
        rst_n = 1'b1;
        drive("arst_post", 1'b0, 1'b1, 1, 1, 0);
        chk("arst_post sum", 16'(s2), 16'd2);
        for (int a = 0; a < 4; a++)
            for (int b = 0; b < 4; b++)
                for (int c = 0; c < 2; c++)
                    drive("exh", 1'b0, 1'b1, a, b, c);
        drive("w8 max", 1'b1, 1'b1, 255, 255, 1);
        chk("w8 max sum", 16'(s8), 16'hff);
        chk("w8 max cout", 16'(co8), 16'd1);
        drive("w8 zero", 1'b1, 1'b1, 0, 0, 0);
        drive("w8 pos_ovf", 1'b1, 1'b1, 127, 1, 0);
        drive("w8 neg_ovf", 1'b1, 1'b1, 128, 128, 0);
        for (int n = 0; n < 10000; n++)
            drive("rnd", 1'b1, $urandom_range(0, 3) != 0,
                  int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                  int'($urandom_range(0, 1)));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
